// File: rtl/knight_uart_pkg.sv
// Shared types and constants for the knight-side UART command endpoint.
package knight_uart_pkg;

  localparam int unsigned FRAME_BITS           = 10;
  localparam int unsigned DEFAULT_CLKS_PER_BIT = 2604;

  typedef enum logic {WAIT_HI, WAIT_LO} asm_state_t;

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

  typedef enum logic {TX_IDLE, TX_BUSY} tx_state_t;

endpackage

// File: rtl/uart_rx_core.sv
// 8N1 receive bit engine: RX synchronizer, start detect with glitch reject,
// mid-bit sampling, byte strobe and framing-error strobe.
module uart_rx_core
  import knight_uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic       start_edge,
  output logic       rx_busy,
  output logic       byte_rdy,
  output logic       frame_err,
  output logic [7:0] rx_byte
);

  localparam int unsigned CW = $clog2(CLKS_PER_BIT);

  logic          rx_ff1, rx_ff2, rx_prev;
  rx_state_t     state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [2:0]    bit_idx, bit_idx_nxt;
  logic [7:0]    shreg, shreg_nxt;
  logic          tick;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_ff1  <= 1'b1;
      rx_ff2  <= 1'b1;
      rx_prev <= 1'b1;
      state   <= RX_IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shreg   <= '0;
    end else begin
      rx_ff1  <= rx;
      rx_ff2  <= rx_ff1;
      rx_prev <= rx_ff2;
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      bit_idx <= bit_idx_nxt;
      shreg   <= shreg_nxt;
    end
  end

  assign start_edge = (state == RX_IDLE) && rx_prev && !rx_ff2;
  assign rx_busy    = (state != RX_IDLE);
  assign tick       = (cnt == '0);
  assign rx_byte    = shreg;

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = tick ? cnt : cnt - 1'b1;
    bit_idx_nxt = bit_idx;
    shreg_nxt   = shreg;
    byte_rdy    = 1'b0;
    frame_err   = 1'b0;
    case (state)
      RX_IDLE: begin
        if (start_edge) begin
          state_nxt = RX_START;
          cnt_nxt   = CW'(CLKS_PER_BIT / 2 - 1);
        end
      end
      RX_START: begin
        // A start bit that is high again at mid-bit was a glitch.
        if (tick) begin
          if (!rx_ff2) begin
            state_nxt   = RX_DATA;
            cnt_nxt     = CW'(CLKS_PER_BIT - 1);
            bit_idx_nxt = '0;
          end else begin
            state_nxt = RX_IDLE;
          end
        end
      end
      RX_DATA: begin
        if (tick) begin
          shreg_nxt = {rx_ff2, shreg[7:1]};
          cnt_nxt   = CW'(CLKS_PER_BIT - 1);
          if (bit_idx == 3'd7) state_nxt = RX_STOP;
          else                 bit_idx_nxt = bit_idx + 1'b1;
        end
      end
      RX_STOP: begin
        if (tick) begin
          state_nxt = RX_IDLE;
          if (rx_ff2) byte_rdy  = 1'b1;
          else        frame_err = 1'b1;
        end
      end
      default: state_nxt = RX_IDLE;
    endcase
  end

endmodule

// File: rtl/cmd_uart_wrapper.sv
// UART command endpoint: assembles two received bytes into a 16-bit command
// and serializes 8-bit responses on TX.
module cmd_uart_wrapper
  import knight_uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int unsigned TIMEOUT_CLKS = 78120
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        RX,
  output logic        TX,
  output logic [15:0] cmd,
  output logic        cmd_rdy,
  input  logic        clr_cmd_rdy,
  input  logic [7:0]  resp,
  input  logic        trmt,
  output logic        tx_done,
  output logic        rx_err
);

  localparam int unsigned CW = $clog2(CLKS_PER_BIT);
  localparam int unsigned TW = $clog2(TIMEOUT_CLKS + 1);

  logic       start_edge, rx_busy, byte_rdy, frame_err;
  logic [7:0] rx_byte;

  uart_rx_core #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx_core (
    .clk       (clk),
    .rst       (rst),
    .rx        (RX),
    .start_edge(start_edge),
    .rx_busy   (rx_busy),
    .byte_rdy  (byte_rdy),
    .frame_err (frame_err),
    .rx_byte   (rx_byte)
  );

  asm_state_t    asm_state, asm_nxt;
  logic [TW-1:0] to_cnt;
  logic [7:0]    hi_byte;
  logic          hi_load, cmd_load, timeout, to_run;

  // The timeout only runs while the line is idle between bytes.
  assign to_run = (asm_state == WAIT_LO) && !rx_busy && !start_edge;

  always_comb begin
    asm_nxt  = asm_state;
    hi_load  = 1'b0;
    cmd_load = 1'b0;
    timeout  = 1'b0;
    case (asm_state)
      WAIT_HI: begin
        if (byte_rdy) begin
          hi_load = 1'b1;
          asm_nxt = WAIT_LO;
        end
      end
      WAIT_LO: begin
        if (byte_rdy) begin
          cmd_load = 1'b1;
          asm_nxt  = WAIT_HI;
        end else if (frame_err) begin
          asm_nxt = WAIT_HI;
        end else if (to_run && to_cnt == TW'(TIMEOUT_CLKS - 1)) begin
          timeout = 1'b1;
          asm_nxt = WAIT_HI;
        end
      end
      default: asm_nxt = WAIT_HI;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) asm_state <= WAIT_HI;
    else     asm_state <= asm_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hi_byte <= '0;
      to_cnt  <= '0;
      cmd     <= '0;
      cmd_rdy <= 1'b0;
      rx_err  <= 1'b0;
    end else begin
      rx_err <= frame_err | timeout;
      if (hi_load) begin
        hi_byte <= rx_byte;
        to_cnt  <= '0;
      end else if (to_run) begin
        to_cnt <= to_cnt + 1'b1;
      end
      if (cmd_load) begin
        cmd     <= {hi_byte, rx_byte};
        cmd_rdy <= 1'b1;
      end else if (clr_cmd_rdy || (start_edge && asm_state == WAIT_HI)) begin
        cmd_rdy <= 1'b0;
      end
    end
  end

  tx_state_t     tx_state, tx_nxt;
  logic [CW-1:0] tx_cnt;
  logic [3:0]    tx_bits;
  logic [8:0]    tx_sh;
  logic          tx_q, tx_accept, tx_tick, tx_last;

  assign tx_accept = (tx_state == TX_IDLE) && trmt;
  assign tx_tick   = (tx_cnt == '0);
  assign tx_last   = (tx_state == TX_BUSY) && tx_tick && (tx_bits == '0);
  assign TX        = tx_q;

  always_comb begin
    tx_nxt = tx_state;
    if (tx_accept)    tx_nxt = TX_BUSY;
    else if (tx_last) tx_nxt = TX_IDLE;
  end

  // Start bit goes straight to the pin; the shifter holds data plus stop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_state <= TX_IDLE;
      tx_q     <= 1'b1;
      tx_done  <= 1'b0;
      tx_sh    <= '0;
      tx_cnt   <= '0;
      tx_bits  <= '0;
    end else begin
      tx_state <= tx_nxt;
      if (tx_accept) begin
        tx_q    <= 1'b0;
        tx_sh   <= {1'b1, resp};
        tx_cnt  <= CW'(CLKS_PER_BIT - 1);
        tx_bits <= 4'(FRAME_BITS - 1);
        tx_done <= 1'b0;
      end else if (tx_state == TX_BUSY) begin
        if (!tx_tick) begin
          tx_cnt <= tx_cnt - 1'b1;
        end else if (tx_bits == '0) begin
          tx_q    <= 1'b1;
          tx_done <= 1'b1;
        end else begin
          tx_q    <= tx_sh[0];
          tx_sh   <= {1'b1, tx_sh[8:1]};
          tx_bits <= tx_bits - 1'b1;
          tx_cnt  <= CW'(CLKS_PER_BIT - 1);
        end
      end
    end
  end

endmodule

// File: tb/tb_cmd_uart_wrapper.sv
// Self-checking bench for cmd_uart_wrapper with scoreboards for commands and TX bits.
module tb_cmd_uart_wrapper;

  localparam int unsigned CPB = 16;
  localparam int unsigned TO  = 480;

  logic        clk = 1'b0;
  logic        rst, RX, TX, cmd_rdy, clr_cmd_rdy, trmt, tx_done, rx_err;
  logic [15:0] cmd;
  logic [7:0]  resp;

  int tests_run = 0;
  int tests_failed = 0;
  int err_count = 0;
  logic [15:0] cmd_q[$];
  logic        bit_q[$];
  logic        rdy_prev = 1'b0;
  logic        err_prev = 1'b0;

  always #5 clk = ~clk;

  cmd_uart_wrapper #(.CLKS_PER_BIT(CPB), .TIMEOUT_CLKS(TO)) dut (
    .clk        (clk),
    .rst        (rst),
    .RX         (RX),
    .TX         (TX),
    .cmd        (cmd),
    .cmd_rdy    (cmd_rdy),
    .clr_cmd_rdy(clr_cmd_rdy),
    .resp       (resp),
    .trmt       (trmt),
    .tx_done    (tx_done),
    .rx_err     (rx_err)
  );

  // Command scoreboard and rx_err pulse monitor.
  always @(negedge clk) begin
    if (rx_err === 1'b1) begin
      err_count++;
      tests_run++;
      if (err_prev === 1'b1) begin
        tests_failed++;
        $display("FAIL rx_err_width: rx_err high on consecutive cycles, want 1-cycle pulse");
      end
    end
    if (cmd_rdy === 1'b1 && rdy_prev !== 1'b1) begin
      tests_run++;
      if (cmd_q.size() == 0) begin
        tests_failed++;
        $display("FAIL cmd_unexpected: got cmd=%h, no command expected", cmd);
      end else begin
        automatic logic [15:0] exp = cmd_q.pop_front();
        if (cmd !== exp) begin
          tests_failed++;
          $display("FAIL cmd_value: got %h want %h", cmd, exp);
        end
      end
    end
    rdy_prev <= cmd_rdy;
    err_prev <= rx_err;
  end

  task automatic uart_send(input logic [7:0] b, input logic stop_bit);
    RX = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      RX = b[i];
      repeat (CPB) @(negedge clk);
    end
    RX = stop_bit;
    repeat (CPB) @(negedge clk);
    RX = 1'b1;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic wait_rdy(output int n);
    n = 0;
    while (cmd_rdy !== 1'b1 && n < 400) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic push_frame(input logic [7:0] b);
    logic [9:0] f;
    f = {1'b1, b, 1'b0};
    for (int i = 0; i < 10; i++) bit_q.push_back(f[i]);
  endtask

  task automatic test_reset;
    rst = 1'b1; RX = 1'b1; trmt = 1'b0; clr_cmd_rdy = 1'b0; resp = '0;
    repeat (3) @(negedge clk);
    tests_run++; if (TX !== 1'b1)       begin tests_failed++; $display("FAIL reset_TX: got %b want 1", TX); end
    tests_run++; if (cmd !== 16'h0000)  begin tests_failed++; $display("FAIL reset_cmd: got %h want 0000", cmd); end
    tests_run++; if (cmd_rdy !== 1'b0)  begin tests_failed++; $display("FAIL reset_cmd_rdy: got %b want 0", cmd_rdy); end
    tests_run++; if (tx_done !== 1'b0)  begin tests_failed++; $display("FAIL reset_tx_done: got %b want 0", tx_done); end
    tests_run++; if (rx_err !== 1'b0)   begin tests_failed++; $display("FAIL reset_rx_err: got %b want 0", rx_err); end
    rst = 1'b0;
    repeat (5) @(negedge clk);
  endtask

  task automatic test_basic_cmd;
    int lat;
    cmd_q.push_back(16'h4331);
    uart_send(8'h43, 1'b1);
    fork
      uart_send(8'h31, 1'b1);
      begin
        lat = 0;
        while (cmd_rdy !== 1'b1 && lat < 300) begin
          @(negedge clk);
          lat++;
        end
      end
    join
    tests_run++;
    if (lat < 150 || lat > 156) begin
      tests_failed++;
      $display("FAIL basic_latency: got %0d cycles want 150..156", lat);
    end
    tests_run++; if (cmd_q.size() != 0) begin tests_failed++; $display("FAIL basic_pending: got %0d pending want 0", cmd_q.size()); end
    clr_cmd_rdy = 1'b1;
    @(negedge clk);
    clr_cmd_rdy = 1'b0;
    tests_run++; if (cmd_rdy !== 1'b0)    begin tests_failed++; $display("FAIL basic_clr: got cmd_rdy=%b want 0", cmd_rdy); end
    tests_run++; if (cmd !== 16'h4331)    begin tests_failed++; $display("FAIL basic_hold: got %h want 4331", cmd); end
  endtask

  task automatic test_timeout;
    int e0, n;
    e0 = err_count;
    cmd_q.push_back(16'h5510);
    uart_send(8'h2A, 1'b1);
    repeat (400) @(negedge clk);
    tests_run++; if (err_count != e0)     begin tests_failed++; $display("FAIL timeout_early: got %0d errors want %0d", err_count - e0, 0); end
    repeat (200) @(negedge clk);
    tests_run++; if (err_count != e0 + 1) begin tests_failed++; $display("FAIL timeout_err: got %0d errors want %0d", err_count - e0, 1); end
    uart_send(8'h55, 1'b1);
    uart_send(8'h10, 1'b1);
    wait_rdy(n);
    tests_run++; if (cmd_rdy !== 1'b1)    begin tests_failed++; $display("FAIL timeout_rdy: got cmd_rdy=%b want 1 after %0d cycles", cmd_rdy, n); end
    tests_run++; if (cmd_q.size() != 0)   begin tests_failed++; $display("FAIL timeout_pending: got %0d pending want 0", cmd_q.size()); end
  endtask

  task automatic test_frame_err;
    int e0, n;
    e0 = err_count;
    uart_send(8'h12, 1'b1);
    uart_send(8'h99, 1'b0);
    repeat (20) @(negedge clk);
    tests_run++; if (err_count != e0 + 1) begin tests_failed++; $display("FAIL frame_err: got %0d errors want 1", err_count - e0); end
    tests_run++; if (cmd_rdy !== 1'b0)    begin tests_failed++; $display("FAIL frame_rdy: got cmd_rdy=%b want 0", cmd_rdy); end
    tests_run++; if (cmd !== 16'h5510)    begin tests_failed++; $display("FAIL frame_hold: got %h want 5510", cmd); end
    cmd_q.push_back(16'h1234);
    uart_send(8'h12, 1'b1);
    uart_send(8'h34, 1'b1);
    wait_rdy(n);
    tests_run++; if (cmd_rdy !== 1'b1)    begin tests_failed++; $display("FAIL frame_recover: got cmd_rdy=%b want 1 after %0d cycles", cmd_rdy, n); end
  endtask

  task automatic test_glitch;
    int e0, n;
    clr_cmd_rdy = 1'b1;
    @(negedge clk);
    clr_cmd_rdy = 1'b0;
    e0 = err_count;
    RX = 1'b0;
    repeat (4) @(negedge clk);
    RX = 1'b1;
    repeat (100) @(negedge clk);
    tests_run++; if (err_count != e0)     begin tests_failed++; $display("FAIL glitch_err: got %0d errors want 0", err_count - e0); end
    tests_run++; if (cmd_rdy !== 1'b0)    begin tests_failed++; $display("FAIL glitch_rdy: got cmd_rdy=%b want 0", cmd_rdy); end
    cmd_q.push_back(16'hABCD);
    uart_send(8'hAB, 1'b1);
    uart_send(8'hCD, 1'b1);
    wait_rdy(n);
    tests_run++; if (cmd_rdy !== 1'b1)    begin tests_failed++; $display("FAIL glitch_after: got cmd_rdy=%b want 1 after %0d cycles", cmd_rdy, n); end
  endtask

  // Frame 0 carries an ignored mid-frame trmt; frame 1 is accepted on the tx_done rise cycle.
  task automatic test_tx;
    @(negedge clk);
    resp = 8'hA5;
    trmt = 1'b1;
    push_frame(8'hA5);
    for (int f = 0; f < 2; f++) begin
      @(negedge clk);
      trmt = 1'b0;
      tests_run++; if (TX !== 1'b0)      begin tests_failed++; $display("FAIL tx_start%0d: got TX=%b want 0", f, TX); end
      tests_run++; if (tx_done !== 1'b0) begin tests_failed++; $display("FAIL tx_done_clr%0d: got %b want 0", f, tx_done); end
      for (int k = 1; k <= 160; k++) begin
        @(negedge clk);
        if (k % 16 == 8) begin
          tests_run++;
          if (bit_q.size() == 0) begin
            tests_failed++;
            $display("FAIL tx_bit%0d_k%0d: got TX=%b, no bit expected", f, k, TX);
          end else begin
            automatic logic eb = bit_q.pop_front();
            if (TX !== eb) begin
              tests_failed++;
              $display("FAIL tx_bit%0d_k%0d: got %b want %b", f, k, TX, eb);
            end
          end
        end
        if (f == 0 && k == 56) begin resp = 8'hFF; trmt = 1'b1; end
        if (f == 0 && k == 57) trmt = 1'b0;
        if (k == 159) begin
          tests_run++; if (tx_done !== 1'b0) begin tests_failed++; $display("FAIL tx_done_early%0d: got %b want 0", f, tx_done); end
        end
        if (k == 160) begin
          tests_run++;
          if (tx_done !== 1'b1 || TX !== 1'b1) begin
            tests_failed++;
            $display("FAIL tx_done_rise%0d: got tx_done=%b TX=%b want 1 1", f, tx_done, TX);
          end
        end
      end
      if (f == 0) begin
        resp = 8'h3C;
        trmt = 1'b1;
        push_frame(8'h3C);
      end
    end
    repeat (5) @(negedge clk);
    tests_run++; if (tx_done !== 1'b1 || TX !== 1'b1) begin tests_failed++; $display("FAIL tx_idle: got tx_done=%b TX=%b want 1 1", tx_done, TX); end
    tests_run++; if (bit_q.size() != 0) begin tests_failed++; $display("FAIL tx_pending: got %0d bits want 0", bit_q.size()); end
  endtask

  task automatic test_reset_mid;
    int n;
    uart_send(8'h77, 1'b1);
    resp = 8'h00;
    trmt = 1'b1;
    @(negedge clk);
    trmt = 1'b0;
    fork
      uart_send(8'h88, 1'b1);
      begin
        repeat (60) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        tests_run++; if (TX !== 1'b1)      begin tests_failed++; $display("FAIL rstmid_TX: got %b want 1", TX); end
        tests_run++; if (cmd !== 16'h0000) begin tests_failed++; $display("FAIL rstmid_cmd: got %h want 0000", cmd); end
        tests_run++; if (cmd_rdy !== 1'b0) begin tests_failed++; $display("FAIL rstmid_rdy: got %b want 0", cmd_rdy); end
      end
    join
    rst = 1'b0;
    repeat (20) @(negedge clk);
    cmd_q.push_back(16'h5AC3);
    uart_send(8'h5A, 1'b1);
    uart_send(8'hC3, 1'b1);
    wait_rdy(n);
    tests_run++; if (cmd_rdy !== 1'b1)  begin tests_failed++; $display("FAIL rstmid_after: got cmd_rdy=%b want 1 after %0d cycles", cmd_rdy, n); end
    tests_run++; if (cmd_q.size() != 0) begin tests_failed++; $display("FAIL rstmid_pending: got %0d pending want 0", cmd_q.size()); end
  endtask

  initial begin
    test_reset();
    test_basic_cmd();
    test_timeout();
    test_frame_err();
    test_glitch();
    test_tx();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #2_000_000;
    tests_run++;
    tests_failed++;
    $display("FAIL watchdog: simulation exceeded time limit");
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/cmd_uart_wrapper.md
# cmd_uart_wrapper

Knight-side UART endpoint that pairs with the remote command sender. Receives 16-bit tour commands as two 8N1 UART bytes (high byte first), presents them atomically as `cmd` with a `cmd_rdy` flag for the command processor, and serializes 8-bit responses (position acks, etc.) back out on `TX`. Sits between the board `RX`/`TX` pins and `cmd_proc` inside `KnightsTour`.

## Interface
- `CLKS_PER_BIT`, 2604, clocks per UART bit (≥ 8, even)
- `TIMEOUT_CLKS`, 78120, max clocks from high-byte stop sample to low-byte start edge before the high byte is discarded
- `clk` in 1: system clock; one clock domain
- `rst` in 1: reset, asynchronous, active-high
- `RX` in 1: serial input, idle high, asynchronous to `clk`
- `TX` out 1: serial output, idle high
- `cmd` out 16: last complete command {high byte, low byte}
- `cmd_rdy` out 1: level, new `cmd` available
- `clr_cmd_rdy` in 1: one-cycle pulse, consumer has taken `cmd`
- `resp` in 8: response byte, sampled on `trmt`
- `trmt` in 1: one-cycle pulse, start transmitting `resp`
- `tx_done` out 1: level, last response fully sent
- `rx_err` out 1: one-cycle pulse, framing error or assembly abort

## Operation
- Reset values: `TX`=1, `cmd`=0, `cmd_rdy`=0, `tx_done`=0, `rx_err`=0; RX synchronizer flops reset to 1; assembler in `WAIT_HI`.
- RX bit engine: 2-flop sync on `RX`; start = synced falling edge while idle; first sample CLKS_PER_BIT/2 after edge (start bit must read 0, else silently return idle — glitch reject); then 8 data samples LSB first, one stop sample, each CLKS_PER_BIT apart. Stop=1 → byte strobe; stop=0 → no strobe, `rx_err` pulse.
- Assembler states: `WAIT_HI`, `WAIT_LO`.
  - `WAIT_HI` + byte strobe → latch `hi_byte`, clear timeout counter, → `WAIT_LO`.
  - `WAIT_LO` + byte strobe → `cmd` ← {hi_byte, byte} in one cycle, set `cmd_rdy`, → `WAIT_HI`.
  - `WAIT_LO` + counter reaches TIMEOUT_CLKS with no start edge → drop hi_byte, `rx_err` pulse, → `WAIT_HI`.
  - `WAIT_LO` + framing error → drop hi_byte, → `WAIT_HI`.
- `cmd` changes only on completed commands; never shows a half-updated value.
- `cmd_rdy` cleared by `clr_cmd_rdy` or by start edge of a new high byte; set beats clear when simultaneous. Unconsumed command overwritten by next one.
- TX: `trmt` while idle loads {stop=1, resp, start=0}; shifts LSB first, CLKS_PER_BIT per bit. `trmt` while busy ignored (no queue). `tx_done` cleared on accepted `trmt`, set at end of stop bit, held until next accepted `trmt`.
- RX and TX fully independent; full-duplex operation required.

## Timing
- RX sync latency: 2 cycles from pin edge to detected edge.
- `cmd_rdy` rises 1 cycle after the low byte's stop-bit sample (≈ 2 + 9.5·CLKS_PER_BIT cycles after low-byte start edge).
- `TX` falls the cycle after accepted `trmt`; each bit exactly CLKS_PER_BIT cycles; `tx_done` rises 10·CLKS_PER_BIT cycles after `TX` falls, same cycle `TX` returns idle.
- Back-to-back `trmt` on the `tx_done` rise cycle accepted; no idle gap required.
- Async `rst` mid-frame: both engines abort immediately, `TX` forced 1, partial bytes discarded.

## Structure
- Package `knight_uart_pkg`: assembler state enum (`WAIT_HI`, `WAIT_LO`), RX/TX bit-engine state enums, `FRAME_BITS`=10, default CLKS_PER_BIT.
- One sub-module: `uart_rx_core` (sync, start detect, bit sampling, byte strobe, framing error); TX shifter and assembler inline in the wrapper.

## Test plan
Sim with CLKS_PER_BIT=16, TIMEOUT_CLKS=480.
- Send bytes 0x43 then 0x31 → `cmd`=16'h4331, `cmd_rdy`=1 within 2+152 cycles of second start edge; `clr_cmd_rdy` pulse → `cmd_rdy`=0, `cmd` holds 0x4331.
- Send 0x2A, wait 600 cycles, send 0x55, 0x10 → `rx_err` pulse at timeout; final `cmd`=16'h5510, no command 0x2A55 ever presented.
- Low byte with stop bit 0 → `rx_err` 1 cycle, `cmd_rdy` stays 0, next pair 0x12,0x34 → `cmd`=0x1234.
- 4-cycle low glitch on idle `RX` → no strobe, no error, assembler stays `WAIT_HI`.
- `trmt` with `resp`=0xA5 → `TX` frame 0,1,0,1,0,0,1,0,1,1 at 16 cycles/bit, `tx_done` at cycle 160 after `TX` falls; second `trmt` mid-frame ignored.
- Assert `rst` mid-RX and mid-TX → `TX`=1 and `cmd_rdy`=0 immediately; subsequent full command received correctly.
